input_debouncer: RTL and testbench

- Conditions a raw, asynchronous, bouncy input into a clean, clock-synchronous level.
- Sits directly upstream of the edge detector: its signal_out drives the detector's signal_in.
- Consists of an N-stage synchronizer, a two-state debounce FSM with a stability counter, and a saturating glitch counter for diagnostics.

---
 rtl/input_debouncer.sv | 127 ++++++++++++
 tb/tb_input_debouncer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : input_debouncer
//  Description : Synchronizes a raw asynchronous input through a flop chain,
//                then qualifies level changes with a two-state debounce FSM
//                and a stability counter. Aborted transitions are counted in
//                a saturating 8-bit diagnostic counter.
//  Revision    : 1.0  initial release
// ============================================================================
module input_debouncer #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 1000,
    parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       signal_in,
    input  logic       glitch_clr,
    output logic       signal_out,
    output logic       busy,
    output logic [7:0] glitch_count
);

    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_WAIT   = 1'b1
    } state_t;

    // Terminal count: the candidate level has been seen for DEBOUNCE_CYCLES
    // consecutive cycles once the counter sits at this value and still differs.
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       c_gc_max   = 8'hFF;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_q;

    state_t                 r_state;
    state_t                 w_state_n;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_n;
    logic                   r_out;
    logic                   w_out_n;
    logic                   r_busy;
    logic                   w_busy_n;
    logic                   w_glitch_inc;
    logic [7:0]             r_gc;

    // Synchronizer chain: only the last stage is ever seen by the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], signal_in};
        end
    end

    assign w_sync_q = r_sync[SYNC_STAGES-1];

    // FSM state, stability counter, debounced level and busy flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_out   <= RESET_LEVEL;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_out   <= w_out_n;
            r_busy  <= w_busy_n;
        end
    end

    // Next-state logic: enter WAIT on any disagreement, abort on bounce-back,
    // commit the new level once the counter reaches its terminal value.
    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_out_n      = r_out;
        w_glitch_inc = 1'b0;
        case (r_state)
            ST_STABLE: begin
                if (w_sync_q != r_out) begin
                    w_state_n = ST_WAIT;
                    w_cnt_n   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (w_sync_q == r_out) begin
                    w_state_n    = ST_STABLE;
                    w_cnt_n      = '0;
                    w_glitch_inc = 1'b1;
                end else if (r_cnt == c_cnt_last) begin
                    w_out_n   = ~r_out;
                    w_state_n = ST_STABLE;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_n = ST_STABLE;
                w_cnt_n   = '0;
            end
        endcase
        // busy is registered from the next state so it tracks WAIT exactly.
        w_busy_n = (w_state_n == ST_WAIT);
    end

    // Saturating glitch counter; a clear request overrides a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gc <= 8'd0;
        end else if (glitch_clr) begin
            r_gc <= 8'd0;
        end else if (w_glitch_inc && (r_gc != c_gc_max)) begin
            r_gc <= r_gc + 8'd1;
        end
    end

    assign signal_out   = r_out;
    assign busy         = r_busy;
    assign glitch_count = r_gc;

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_debouncer
//  Description : Self-checking bench for input_debouncer. A run-length
//                reference model predicts signal_out, busy and glitch_count
//                every cycle; directed sequences check latency, bounce,
//                saturation, clear priority, mid-WAIT reset and a large
//                parameter set on a second instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_input_debouncer;

    localparam int   S_A  = 2;
    localparam int   D_A  = 4;
    localparam int   S_B  = 3;
    localparam int   D_B  = 1000;
    localparam logic RL   = 1'b0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sig_in = 1'b0;
    logic       glitch_clr = 1'b0;
    logic       signal_out;
    logic       busy;
    logic [7:0] glitch_count;

    logic       sig_in_b = 1'b0;
    logic       signal_out_b;
    logic       busy_b;
    logic [7:0] glitch_count_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the level the FSM sees is the input delayed by the
    // synchronizer depth; m_run counts consecutive cycles of disagreement.
    logic m_pipe [S_A];
    logic m_out;
    int   m_run;
    int   m_gc;

    always #5 clk = ~clk;

    input_debouncer #(
        .SYNC_STAGES     (S_A),
        .DEBOUNCE_CYCLES (D_A),
        .RESET_LEVEL     (RL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .signal_in    (sig_in),
        .glitch_clr   (glitch_clr),
        .signal_out   (signal_out),
        .busy         (busy),
        .glitch_count (glitch_count)
    );

    input_debouncer #(
        .SYNC_STAGES     (S_B),
        .DEBOUNCE_CYCLES (D_B),
        .RESET_LEVEL     (RL)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .signal_in    (sig_in_b),
        .glitch_clr   (1'b0),
        .signal_out   (signal_out_b),
        .busy         (busy_b),
        .glitch_count (glitch_count_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic seen;
        logic inc;
        if (rst) begin
            for (int i = 0; i < S_A; i++) m_pipe[i] = RL;
            m_out = RL;
            m_run = 0;
            m_gc  = 0;
        end else begin
            seen = m_pipe[S_A-1];
            for (int i = S_A - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = sig_in;
            inc = 1'b0;
            if (seen != m_out) begin
                m_run++;
                if (m_run == D_A) begin
                    m_out = ~m_out;
                    m_run = 0;
                end
            end else begin
                if (m_run > 0) inc = 1'b1;
                m_run = 0;
            end
            if (glitch_clr) m_gc = 0;
            else if (inc && m_gc < 255) m_gc++;
        end
    endtask

    // One clock: model follows the active edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("model_out",    signal_out,   m_out);
        check("model_busy",   busy,         (m_run > 0) ? 1 : 0);
        check("model_glitch", glitch_count, m_gc);
    endtask

    // Edges (0-based) until signal_out reaches lvl; -1 if the bound expires.
    task automatic edges_until_out(input logic lvl, output int n);
        n = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (signal_out == lvl) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int first_out;
        int first_busy;

        // Reset with input high.
        sig_in = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        repeat (3) tick();
        check("rst_out",    signal_out,   0);
        check("rst_busy",   busy,         0);
        check("rst_glitch", glitch_count, 0);
        rst = 1'b0;
        edges_until_out(1'b1, n);
        check("rst_release_latency", n, 5);

        // Return low, then a clean rise and a clean fall with exact busy timing.
        sig_in = 1'b0;
        edges_until_out(1'b0, n);
        check("settle_low", n, 5);
        repeat (2) tick();
        for (int dir = 0; dir < 2; dir++) begin
            sig_in = (dir == 0);
            for (int e = 0; e <= 5; e++) begin
                tick();
                check("edge_busy", busy, (e >= 2 && e <= 4) ? 1 : 0);
                check("edge_out",  signal_out, (e >= 5) ? int'(dir == 0) : int'(dir != 0));
            end
            check("edge_glitch", glitch_count, 0);
            repeat (2) tick();
        end

        // Bounce: high 3, low 2, then high and held.
        sig_in = 1'b1; repeat (3) tick();
        sig_in = 1'b0; repeat (2) tick();
        check("bounce_out_hold", signal_out, 0);
        sig_in = 1'b1;
        edges_until_out(1'b1, n);
        check("bounce_latency", n, 5);
        check("bounce_glitch", glitch_count, 1);

        // Return low for saturation run.
        sig_in = 1'b0;
        edges_until_out(1'b0, n);
        repeat (2) tick();

        // 300 glitches of 3 cycles high, 4 low.
        for (int g = 0; g < 300; g++) begin
            sig_in = 1'b1; repeat (3) tick();
            sig_in = 1'b0; repeat (4) tick();
        end
        check("sat_255", glitch_count, 255);
        sig_in = 1'b1; repeat (3) tick();
        sig_in = 1'b0; repeat (4) tick();
        check("sat_stays", glitch_count, 255);

        // Clear coincides with an increment: samples high at edges 0..2,
        // the bounce-back is seen (and counted) at edge 5.
        sig_in = 1'b1; repeat (3) tick();
        sig_in = 1'b0; repeat (2) tick();
        check("clr_pre_busy", busy, 1);
        glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
        check("clr_wins", glitch_count, 0);
        check("clr_left_wait", busy, 0);
        repeat (3) tick();

        // Reset while in WAIT with counter at 2 (after edge 3).
        sig_in = 1'b1;
        repeat (4) tick();
        check("midwait_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midwait_out",    signal_out,   0);
        check("midwait_busy0",  busy,         0);
        check("midwait_glitch", glitch_count, 0);
        edges_until_out(1'b1, n);
        check("midwait_full_latency", n, 5);

        // Randomized traffic with occasional clears and resets.
        for (int seg = 0; seg < 120; seg++) begin
            sig_in = 1'($urandom_range(0, 1));
            for (int k = 0; k < int'($urandom_range(1, 9)); k++) begin
                glitch_clr = ($urandom_range(0, 15) == 0);
                rst        = ($urandom_range(0, 99) == 0);
                tick();
            end
        end
        glitch_clr = 1'b0;
        rst        = 1'b0;
        sig_in     = 1'b0;
        repeat (12) tick();

        // Large-parameter instance: clean rise must land exactly on edge S+D-1.
        check("sweep_pre_out", signal_out_b, 0);
        sig_in_b   = 1'b1;
        first_out  = -1;
        first_busy = -1;
        for (int e = 0; e < 1100; e++) begin
            tick();
            if (first_busy < 0 && busy_b)       first_busy = e;
            if (first_out  < 0 && signal_out_b) first_out  = e;
        end
        check("sweep_busy_edge", first_busy, S_B);
        check("sweep_out_edge",  first_out,  S_B + D_B - 1);
        check("sweep_busy_end",  busy_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
